// File: rtl/alu_share_ctrl.sv
// Arbitrates two requesters onto one shared combinational ALU and owns the
// processor-flags register so carry-using ops see committed flags only.
module alu_share_ctrl #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned FLAGS_WIDTH = 4,
    parameter int unsigned OP_WIDTH    = 4
) (
    input  logic                   master_clk,
    input  logic                   rst_n,
    input  logic                   req0,
    input  logic                   req1,
    input  logic [OP_WIDTH-1:0]    op0,
    input  logic [OP_WIDTH-1:0]    op1,
    input  logic [WIDTH-1:0]       a0,
    input  logic [WIDTH-1:0]       b0,
    input  logic [WIDTH-1:0]       a1,
    input  logic [WIDTH-1:0]       b1,
    output logic                   ack0,
    output logic                   ack1,
    output logic                   done0,
    output logic                   done1,
    output logic [WIDTH-1:0]       result,
    output logic [FLAGS_WIDTH-1:0] flags,
    input  logic                   flags_load,
    input  logic [FLAGS_WIDTH-1:0] flags_wdata,
    output logic                   busy,
    output logic [OP_WIDTH-1:0]    alu_oper,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output logic [FLAGS_WIDTH-1:0] alu_flags_in,
    input  logic [WIDTH-1:0]       alu_out,
    input  logic [FLAGS_WIDTH-1:0] alu_flags_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                 state_q,  state_d;
    logic [OP_WIDTH-1:0]    op_q,     op_d;
    logic [WIDTH-1:0]       a_q,      a_d;
    logic [WIDTH-1:0]       b_q,      b_d;
    logic                   owner_q,  owner_d;
    logic                   last_q,   last_d;
    logic [WIDTH-1:0]       result_q, result_d;
    logic [FLAGS_WIDTH-1:0] flags_q,  flags_d;
    logic                   ack0_q,   ack0_d;
    logic                   ack1_q,   ack1_d;
    logic                   done0_q,  done0_d;
    logic                   done1_q,  done1_d;
    logic                   busy_q,   busy_d;
    logic                   pick_c;

    // State and datapath registers; reset aborts any in-flight operation.
    always_ff @(posedge master_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            result_q <= '0;
            flags_q  <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            busy_q   <= busy_d;
        end
    end

    // Round-robin pick: on a tie the port not granted last wins.
    always_comb begin
        pick_c = 1'b0;
        if (req0 && req1) begin
            pick_c = ~last_q;
        end else if (req1) begin
            pick_c = 1'b1;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        owner_d  = owner_q;
        last_d   = last_q;
        result_d = result_q;
        flags_d  = flags_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        busy_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (flags_load) begin
                    flags_d = flags_wdata;
                end else if (req0 || req1) begin
                    owner_d = pick_c;
                    last_d  = pick_c;
                    op_d    = pick_c ? op1 : op0;
                    a_d     = pick_c ? a1  : a0;
                    b_d     = pick_c ? b1  : b0;
                    ack0_d  = ~pick_c;
                    ack1_d  = pick_c;
                    busy_d  = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d = alu_out;
                flags_d  = alu_flags_out;
                done0_d  = ~owner_q;
                done1_d  = owner_q;
                busy_d   = 1'b1;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ack0         = ack0_q;
    assign ack1         = ack1_q;
    assign done0        = done0_q;
    assign done1        = done1_q;
    assign busy         = busy_q;
    assign result       = result_q;
    assign flags        = flags_q;
    assign alu_oper     = op_q;
    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_flags_in = flags_q;

endmodule
